// File: rtl/phase_pkg.sv
// phase_pkg: shared constants, state type and saturating counter helper for phase_loader
package phase_pkg;
    localparam int PHASE_W = 7;
    localparam logic [7:0] SYNC_BYTE = 8'hFF;
    typedef enum logic [1:0] {IDLE, LOAD, CHECK} state_t;
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return v + {7'd0, v != 8'hFF};
    endfunction
endpackage

// File: rtl/gap_timer.sv
// gap_timer: counts idle cycles inside a frame; expired pulses when the gap reaches TIMEOUT_CYCLES
module gap_timer #(
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic clock_slow,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] count;
    // fires in the cycle whose edge would make the count reach TIMEOUT_CYCLES; a byte wins
    assign expired = enable && !clear && count == LAST;
    always_ff @(posedge clock_slow) begin
        if (reset || clear || !enable || expired) count <= '0;
        else count <= count + 1'b1;
    end
endmodule

// File: rtl/phase_loader.sv
// phase_loader: frames and checksums a byte stream into per-channel phase words, committing all at once
module phase_loader
    import phase_pkg::*;
#(
    parameter int NUM_CHANNELS   = 16,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic                              clock_slow,
    input  logic                              reset,
    input  logic                              rx_valid,
    input  logic [7:0]                        rx_data,
    output logic [PHASE_W*NUM_CHANNELS-1:0]   phase_shift_flat,
    output logic                              apply_shift,
    output logic                              frame_ok,
    output logic                              frame_err,
    output logic [7:0]                        err_count,
    output logic                              busy
);
    localparam int IW = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CHANNELS - 1);
    state_t state;
    logic [IW-1:0] index;
    logic [PHASE_W-1:0] xor_acc;
    logic [PHASE_W-1:0] stage [NUM_CHANNELS];
    logic expired;
    gap_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_gap (
        .clock_slow(clock_slow),
        .reset(reset),
        .clear(rx_valid),
        .enable(state != IDLE),
        .expired(expired)
    );
    always_ff @(posedge clock_slow) begin
        if (reset) begin
            state <= IDLE;
            index <= '0;
            xor_acc <= '0;
            phase_shift_flat <= '0;
            apply_shift <= 1'b0;
            frame_ok <= 1'b0;
            frame_err <= 1'b0;
            err_count <= '0;
            busy <= 1'b0;
            for (int k = 0; k < NUM_CHANNELS; k++) stage[k] <= '0;
        end else begin
            apply_shift <= 1'b0;
            frame_ok <= 1'b0;
            frame_err <= 1'b0;
            if (rx_valid) begin
                if (rx_data == SYNC_BYTE) begin
                    // a SYNC inside a frame aborts it and starts the next one immediately
                    if (state != IDLE) begin
                        frame_err <= 1'b1;
                        err_count <= sat_inc(err_count);
                    end
                    state <= LOAD;
                    busy <= 1'b1;
                    index <= '0;
                    xor_acc <= '0;
                end else if (state == IDLE) begin
                    state <= IDLE;
                end else if (rx_data[7]) begin
                    frame_err <= 1'b1;
                    err_count <= sat_inc(err_count);
                    state <= IDLE;
                    busy <= 1'b0;
                end else if (state == LOAD) begin
                    stage[index] <= rx_data[PHASE_W-1:0];
                    xor_acc <= xor_acc ^ rx_data[PHASE_W-1:0];
                    index <= index + 1'b1;
                    if (index == LAST_IDX) state <= CHECK;
                end else begin
                    if (rx_data[PHASE_W-1:0] == xor_acc) begin
                        for (int k = 0; k < NUM_CHANNELS; k++)
                            phase_shift_flat[PHASE_W*k +: PHASE_W] <= stage[k];
                        apply_shift <= 1'b1;
                        frame_ok <= 1'b1;
                    end else begin
                        frame_err <= 1'b1;
                        err_count <= sat_inc(err_count);
                    end
                    state <= IDLE;
                    busy <= 1'b0;
                end
            end else if (expired) begin
                frame_err <= 1'b1;
                err_count <= sat_inc(err_count);
                state <= IDLE;
                busy <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_phase_loader.sv
// tb_phase_loader: randomized scoreboard bench with a frame-level reference model
module tb_phase_loader;
    localparam int N = 4;
    localparam int TO = 50;
    logic clock_slow = 1'b0;
    logic reset = 1'b1;
    logic rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [7*N-1:0] phase_shift_flat;
    logic apply_shift, frame_ok, frame_err, busy;
    logic [7:0] err_count;

    phase_loader #(.NUM_CHANNELS(N), .TIMEOUT_CYCLES(TO)) dut (
        .clock_slow(clock_slow),
        .reset(reset),
        .rx_valid(rx_valid),
        .rx_data(rx_data),
        .phase_shift_flat(phase_shift_flat),
        .apply_shift(apply_shift),
        .frame_ok(frame_ok),
        .frame_err(frame_err),
        .err_count(err_count),
        .busy(busy)
    );

    always #5 clock_slow = ~clock_slow;

    typedef struct packed {
        logic [2:0] p;
        logic [7*N-1:0] flat;
        logic [7:0] cnt;
    } ev_t;

    ev_t evq [1024];
    int wr_ptr = 0;
    int rd_ptr = 0;
    ev_t e;
    logic [6:0] commit [N];
    int errs_m = 0;
    bit active = 0;
    logic [7:0] fr [$];
    logic [7:0] seq [$];
    int gap = 0;
    logic snap_busy = 1'b0;
    logic [7*N-1:0] snap_flat = '0;
    logic [7:0] snap_cnt = 8'h00;
    bit done = 0;
    int checks = 0;
    int errors = 0;

    function automatic logic [7*N-1:0] flat_of();
        logic [7*N-1:0] f;
        for (int k = 0; k < N; k++) f[7*k +: 7] = commit[k];
        return f;
    endfunction

    task automatic push(input logic [2:0] p);
        evq[wr_ptr % 1024] = '{p: p, flat: flat_of(), cnt: 8'(errs_m)};
        wr_ptr++;
    endtask

    task automatic model_err();
        errs_m = errs_m < 255 ? errs_m + 1 : 255;
        push(3'b001);
    endtask

    // Frame-level model: bytes since the last SYNC are collected and judged when complete
    task automatic model_byte(input logic [7:0] b);
        logic [6:0] x;
        gap = 0;
        if (b == 8'hFF) begin
            if (active) model_err();
            active = 1;
            fr.delete();
        end else if (active && b >= 8'h80) begin
            model_err();
            active = 0;
        end else if (active) begin
            fr.push_back(b);
            if (fr.size() == N + 1) begin
                x = 7'h00;
                for (int i = 0; i < N; i++) x ^= fr[i][6:0];
                if ({1'b0, x} == fr[N]) begin
                    for (int i = 0; i < N; i++) commit[i] = fr[i][6:0];
                    push(3'b110);
                end else model_err();
                active = 0;
            end
        end
    endtask

    task automatic model_idle();
        if (active) begin
            gap++;
            if (gap == TO) begin
                model_err();
                active = 0;
                gap = 0;
            end
        end
    endtask

    task automatic settle();
        @(posedge clock_slow);
        #1;
        snap_busy = active;
        snap_flat = flat_of();
        snap_cnt = 8'(errs_m);
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data = b;
        model_byte(b);
        settle();
        rx_valid = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            model_idle();
            settle();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        active = 0;
        fr.delete();
        gap = 0;
        errs_m = 0;
        for (int k = 0; k < N; k++) commit[k] = 7'h00;
        settle();
        reset = 1'b0;
    endtask

    task automatic frame(input logic [7*N-1:0] v, input bit bad);
        logic [6:0] x;
        x = 7'h00;
        send(8'hFF);
        for (int k = 0; k < N; k++) begin
            send({1'b0, v[7*k +: 7]});
            x ^= v[7*k +: 7];
        end
        send({1'b0, bad ? x ^ 7'($urandom_range(1, 127)) : x});
    endtask

    task automatic send_seq();
        foreach (seq[i]) send(seq[i]);
    endtask

    always @(negedge clock_slow) begin
        if (done) begin
            checks++;
            if (rd_ptr != wr_ptr) begin
                errors++;
                $display("FAIL pending_events got=%0d want=0", wr_ptr - rd_ptr);
            end
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end else if (!reset) begin
            if (apply_shift || frame_ok || frame_err) begin
                checks++;
                if (rd_ptr == wr_ptr) begin
                    errors++;
                    $display("FAIL unexpected_pulse got=%b flat=%h cnt=%0d want=none",
                             {apply_shift, frame_ok, frame_err}, phase_shift_flat, err_count);
                end else begin
                    e = evq[rd_ptr % 1024];
                    rd_ptr++;
                    if ({apply_shift, frame_ok, frame_err} !== e.p || phase_shift_flat !== e.flat || err_count !== e.cnt) begin
                        errors++;
                        $display("FAIL event got=%b/%h/%0d want=%b/%h/%0d",
                                 {apply_shift, frame_ok, frame_err}, phase_shift_flat, err_count, e.p, e.flat, e.cnt);
                    end
                end
            end
            checks++;
            if ({busy, phase_shift_flat, err_count} !== {snap_busy, snap_flat, snap_cnt}) begin
                errors++;
                $display("FAIL state got=%b/%h/%0d want=%b/%h/%0d",
                         busy, phase_shift_flat, err_count, snap_busy, snap_flat, snap_cnt);
            end
        end
    end

    initial begin
        logic [7*N-1:0] v;
        do_reset();
        idle(2);
        frame({7'h04, 7'h03, 7'h02, 7'h01}, 0);
        idle(1);
        seq = '{8'hFF, 8'h10, 8'h20, 8'h30, 8'h40, 8'h00};
        send_seq();
        idle(2);
        seq = '{8'hFF, 8'h11, 8'h22, 8'hFF, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0C};
        send_seq();
        seq = '{8'hFF, 8'h01};
        send_seq();
        idle(60);
        send_seq();
        idle(TO - 1);
        seq = '{8'h02, 8'h03, 8'h04, 8'h04};
        send_seq();
        seq = '{8'hFF, 8'h01, 8'h02};
        send_seq();
        do_reset();
        seq = '{8'h03, 8'h04};
        send_seq();
        idle(3);
        frame({7'h2A, 7'h15, 7'h7F, 7'h00}, 0);
        frame({7'h01, 7'h01, 7'h01, 7'h01}, 0);
        repeat (150) begin
            v = 28'($urandom);
            case ($urandom % 6)
                0, 1, 2: frame(v, 0);
                3: frame(v, 1);
                4: repeat ($urandom_range(1, 5)) send(8'($urandom_range(0, 255)));
                default: begin
                    send(8'hFF);
                    repeat ($urandom_range(0, N)) send(8'($urandom_range(0, 127)));
                    idle($urandom_range(40, 60));
                end
            endcase
            idle($urandom_range(0, 3));
        end
        repeat (300) frame(28'($urandom), 1);
        idle(2);
        frame(28'($urandom), 0);
        idle(3);
        done = 1;
        #20;
        $display("FAIL no_finish got=running want=finished");
        $fatal(1);
    end
endmodule
